// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle datapath: walks each instruction through
// fetch/decode/execute/memory/writeback, with ready-gated memory and a retire counter.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic [1:0]       brkind,
    output logic             flagwrite,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdest,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsource,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BEN   = 6'b000110;
    localparam logic [5:0] OP_BVF   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    state_t           state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            retired_q <= retired_d;
        end
    end

    // Next state; the opcode is captured in DECODE so later states never look at the IR.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        retire_evt = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                opcode_d = opcode;
                case (opcode)
                    OP_LW, OP_SW:           state_d = S_MEMADDR;
                    OP_RTYPE:               state_d = S_REXEC;
                    OP_BEQ, OP_BEN, OP_BVF: state_d = S_BRANCH;
                    OP_J:                   state_d = S_JUMP;
                    OP_ADDI:                state_d = S_ADDIEX;
                    default:                state_d = S_TRAP;
                endcase
            end
            S_MEMADDR: begin
                state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                state_d    = S_FETCH;
                retire_evt = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d    = S_FETCH;
                    retire_evt = 1'b1;
                end
            end
            S_REXEC:  state_d = S_RWB;
            S_RWB: begin
                state_d    = S_FETCH;
                retire_evt = 1'b1;
            end
            S_BRANCH, S_JUMP: begin
                state_d    = S_FETCH;
                retire_evt = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin
                state_d    = S_FETCH;
                retire_evt = 1'b1;
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (retire_evt && !(&retired_q)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    assign retired = retired_q;

    // Moore outputs; irwrite/pcwrite in FETCH are the only ones that follow mem_ready.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        brkind      = 2'b00;
        flagwrite   = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regdest     = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_RT;
        aluop       = ALU_ADD;
        pcsource    = PCSRC_ALU;
        trap        = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
            end
            S_MEMADDR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_REXEC: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdest  = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = ALU_SUB;
                pcsource    = PCSRC_ALUOUT;
                pcwritecond = 1'b1;
                if (opcode_q == OP_BEN) begin
                    brkind    = 2'b01;
                    flagwrite = 1'b1;
                end else if (opcode_q == OP_BVF) begin
                    brkind    = 2'b10;
                    flagwrite = 1'b1;
                end
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b1;
            end
        endcase
        // Strobes are gated by reset so nothing is written while the state register is being cleared.
        if (reset) begin
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            irwrite     = 1'b0;
            regwrite    = 1'b0;
            memwrite    = 1'b0;
            memread     = 1'b0;
            flagwrite   = 1'b0;
        end
    end

endmodule
